// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory arbiter: FSM states, response owner, NOP word.
// Also holds the out-of-range address test used by both requesters.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DBG   = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IF     = 2'd1,
    OWN_DBG_RD = 2'd2,
    OWN_DBG_WR = 2'd3
  } owner_t;

  localparam logic [31:0] NOP = 32'h00000013;

  // True when any byte-address bit above the word index is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Counts consecutive denied debug-request cycles, saturating at STARVE_MAX.
// Latency: count visible the cycle after a denial; clears on grant or idle request.
// Backpressure: none, free-running observer of req/gnt.
module imem_starve_ctr #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starved
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      if (cnt != CW'(STARVE_MAX)) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign starved = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Shares one synchronous instruction memory between IF fetch and a debug/loader port.
// Latency: grant combinational, read data and rvalid one cycle after grant.
// Backpressure: requester waits while its gnt is low; debug can lock out fetch.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  owner_t      owner;
  logic        err_q;
  logic [31:0] if_hold;
  logic [31:0] dbg_hold;
  logic        starved;
  logic        if_oor;
  logic        dbg_oor;

  assign if_oor  = addr_oor(if_addr, ADDR_W);
  assign dbg_oor = addr_oor(dbg_addr, ADDR_W);

  imem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .dbg_req (dbg_req),
    .dbg_gnt (dbg_gnt),
    .starved (starved)
  );

  // Grants are suppressed while reset is held so nothing reaches the memory.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      case (state)
        ST_LOCK: dbg_gnt = dbg_req;
        default: begin
          if (if_req && !(starved && dbg_req)) if_gnt = 1'b1;
          else                                 dbg_gnt = dbg_req;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = !if_oor;
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (dbg_gnt) begin
      mem_en    = !dbg_oor;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[ADDR_W+1:2];
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      owner    <= OWN_NONE;
      err_q    <= 1'b0;
      if_hold  <= NOP;
      dbg_hold <= '0;
    end else begin
      case (state)
        ST_FETCH: if (dbg_gnt) state <= dbg_lock ? ST_LOCK : ST_DBG;
        ST_DBG:   state <= (dbg_gnt && dbg_lock) ? ST_LOCK : ST_FETCH;
        ST_LOCK:  if (!dbg_lock) state <= ST_FETCH;
        default:  state <= ST_FETCH;
      endcase

      if (if_gnt) begin
        owner <= OWN_IF;
        err_q <= if_oor;
      end else if (dbg_gnt) begin
        owner <= dbg_we ? OWN_DBG_WR : OWN_DBG_RD;
        err_q <= dbg_oor;
      end else begin
        owner <= OWN_NONE;
        err_q <= 1'b0;
      end

      if (owner == OWN_IF)     if_hold  <= if_rdata;
      if (owner == OWN_DBG_RD) dbg_hold <= dbg_rdata;
    end
  end

  assign if_rvalid  = (owner == OWN_IF);
  assign if_rdata   = if_rvalid ? (err_q ? NOP : mem_rdata) : if_hold;
  assign dbg_rvalid = (owner == OWN_DBG_RD);
  assign dbg_err    = ((owner == OWN_DBG_RD) || (owner == OWN_DBG_WR)) && err_q;
  assign dbg_rdata  = dbg_rvalid ? (err_q ? 32'd0 : mem_rdata) : dbg_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 256-word synchronous memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dbg_req, dbg_we, dbg_lock;
  logic [31:0] if_addr, dbg_addr, dbg_wdata;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] if_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int nvec = 0;
  int nmis = 0;

  imem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_err    (dbg_err),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
  task automatic step(input logic r, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe, input logic dlock,
                      input logic [31:0] daddr, input logic [31:0] dwdata);
    @(posedge clk);
    #1;
    rst       = r;
    if_req    = ireq;
    if_addr   = iaddr;
    dbg_req   = dreq;
    dbg_we    = dwe;
    dbg_lock  = dlock;
    dbg_addr  = daddr;
    dbg_wdata = dwdata;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem_rdata = 32'd0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
    dbg_addr = 32'h4; dbg_wdata = 32'hFFFFFFFF;
    #2 rst = 1'b0;

    // Reset with both requesters active
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hFFFFFFFF);
    chk("rst_if_gnt",     32'(if_gnt),     32'd0);
    chk("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
    chk("rst_mem_en",     32'(mem_en),     32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_wdata",  mem_wdata,       32'd0);
    chk("rst_if_rvalid",  32'(if_rvalid),  32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_dbg_err",    32'(dbg_err),    32'd0);
    chk("rst_if_rdata",   if_rdata,        32'h00000013);
    chk("rst_dbg_rdata",  dbg_rdata,       32'd0);

    // Fetch stream 0,4,8; first cycle out of reset arbitrates
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f0_gnt",  32'(if_gnt),   32'd1);
    chk("f0_en",   32'(mem_en),   32'd1);
    chk("f0_addr", 32'(mem_addr), 32'd0);
    step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f1_addr",   32'(mem_addr),  32'd1);
    chk("f0_rvalid", 32'(if_rvalid), 32'd1);
    chk("f0_rdata",  if_rdata,       32'hC0DE0000);
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f2_addr",  32'(mem_addr), 32'd2);
    chk("f1_rdata", if_rdata,      32'hC0DE0001);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f2_rvalid", 32'(if_rvalid), 32'd1);
    chk("f2_rdata",  if_rdata,       32'hC0DE0002);
    chk("idle_gnt",  32'(if_gnt),    32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_rvalid", 32'(if_rvalid), 32'd0);
    chk("hold_rdata",  if_rdata,       32'hC0DE0002);

    // Starvation: debug denied four cycles, granted on the fifth
    for (int c = 1; c <= 4; c++) begin
      step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
      chk($sformatf("starve%0d_if", c),  32'(if_gnt),  32'd1);
      chk($sformatf("starve%0d_dbg", c), 32'(dbg_gnt), 32'd0);
    end
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("starve5_dbg",  32'(dbg_gnt),  32'd1);
    chk("starve5_if",   32'(if_gnt),   32'd0);
    chk("starve5_addr", 32'(mem_addr), 32'd2);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("starve6_if",     32'(if_gnt),     32'd1);
    chk("starve6_dbg",    32'(dbg_gnt),    32'd0);
    chk("starve_rvalid",  32'(dbg_rvalid), 32'd1);
    chk("starve_rdata",   dbg_rdata,       32'hC0DE0002);

    // Locked load of two words
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h00500513);
    chk("lock_a_dbg",   32'(dbg_gnt),   32'd1);
    chk("lock_a_we",    32'(mem_we),    32'd1);
    chk("lock_a_wdata", mem_wdata,      32'h00500513);
    chk("lock_a_ifrd",  if_rdata,       32'hC0DE0004);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h4, 32'h00500513);
    chk("lock_b_if",   32'(if_gnt),   32'd0);
    chk("lock_b_dbg",  32'(dbg_gnt),  32'd1);
    chk("lock_b_addr", 32'(mem_addr), 32'd1);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lock_c_if",     32'(if_gnt),     32'd0);
    chk("wr_no_rvalid",  32'(dbg_rvalid), 32'd0);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("unlock_if", 32'(if_gnt), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd0_gnt",   32'(dbg_gnt), 32'd1);
    chk("unlock_rd", if_rdata,     32'hC0DE0004);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd0_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("rd0_rdata",  dbg_rdata,       32'h00500513);
    chk("rd0_err",    32'(dbg_err),    32'd0);

    // Out-of-range debug read, then out-of-range fetch
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
    chk("oor_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("oor_dbg_en",  32'(mem_en),  32'd0);
    step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor_err",      32'(dbg_err),    32'd1);
    chk("oor_rvalid",   32'(dbg_rvalid), 32'd1);
    chk("oor_rdata",    dbg_rdata,       32'd0);
    chk("oor_if_gnt",   32'(if_gnt),     32'd1);
    chk("oor_if_en",    32'(mem_en),     32'd0);
    step(1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor_if_rdata", if_rdata,        32'h00000013);
    chk("oor_err_clr",  32'(dbg_err),    32'd0);
    chk("lsb_addr",     32'(mem_addr),   32'd1);
    chk("lsb_en",       32'(mem_en),     32'd1);

    // Reset lands while a debug read is outstanding
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("lsb_rdata",  if_rdata,      32'h00500513);
    chk("mid_dbg_gnt", 32'(dbg_gnt), 32'd1);
    #1 rst = 1'b0;
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("mid_rvalid",   32'(dbg_rvalid), 32'd0);
    chk("mid_gnt",      32'(dbg_gnt),    32'd0);
    chk("mid_en",       32'(mem_en),     32'd0);
    chk("mid_if_rdata", if_rdata,        32'h00000013);
    chk("mid_dbg_rd",   dbg_rdata,       32'd0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("mid2_if_rdata", if_rdata,        32'h00000013);
    chk("mid2_rvalid",   32'(if_rvalid),  32'd0);
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post_if_gnt", 32'(if_gnt), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post_rvalid", 32'(if_rvalid), 32'd1);
    chk("post_rdata",  if_rdata,       32'h00500513);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, word-index width of the shared instruction memory (256 words).
REQ-002 Parameter: STARVE_MAX, 4, consecutive denied debug-request cycles before debug is forced ahead of fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 if_req  input  1  fetch request from the IF stage.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid; asserted one cycle after if_gnt.
REQ-009 if_rdata  output  32  fetched instruction.
REQ-010 dbg_req, dbg_we, dbg_lock  input  1 each  debug/loader request, write enable and bus lock.
REQ-011 dbg_addr, dbg_wdata  input  32 each  debug byte address and write data.
REQ-012 dbg_gnt, dbg_rvalid, dbg_err  output  1 each  debug grant, read-data valid and address error.
REQ-013 dbg_rdata  output  32  debug read data.
REQ-014 mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-015 mem_addr  output  ADDR_W  memory word index, equal to the byte address bits [ADDR_W+1:2].
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  synchronous memory read data, valid one cycle after mem_en.

Function
REQ-018 The state machine SHALL have three states: FETCH (fetch has priority), DBG (debug served, not locked) and LOCK (debug owns the memory exclusively).
REQ-019 In FETCH, a cycle with if_req=1 SHALL grant fetch unless the starvation counter equals STARVE_MAX and dbg_req=1, in which case debug SHALL be granted.
REQ-020 In FETCH, a cycle with if_req=0 and dbg_req=1 SHALL grant debug.
REQ-021 Grants SHALL be combinational and one-hot; mem_en, mem_we, mem_addr and mem_wdata SHALL come from the granted requester in the same cycle.
REQ-022 mem_we SHALL equal dbg_we when debug is granted and 0 otherwise.
REQ-023 The starvation counter SHALL increment, saturating at STARVE_MAX, on every cycle with dbg_req=1 and dbg_gnt=0.
REQ-024 The starvation counter SHALL clear on dbg_gnt=1 and on any cycle with dbg_req=0.
REQ-025 A debug grant with dbg_lock=1 SHALL move the state machine to LOCK.
REQ-026 In LOCK, if_gnt SHALL be 0, debug SHALL be granted whenever dbg_req=1, and the state machine SHALL return to FETCH on the first cycle with dbg_lock=0.
REQ-027 A debug grant with dbg_lock=0 SHALL enter DBG for one cycle, then return to FETCH.
REQ-028 An owner register SHALL record the granted requester and read/write type so that mem_rdata is steered to if_rdata or dbg_rdata one cycle after the grant, with the matching rvalid pulsed for one cycle.
REQ-029 Debug writes SHALL produce no dbg_rvalid.
REQ-030 A debug address with bits [31:ADDR_W+2] nonzero SHALL be granted but SHALL not assert mem_en, and SHALL pulse dbg_err (with dbg_rvalid for reads) one cycle later, with dbg_rdata = 0.
REQ-031 An out-of-range fetch address SHALL not assert mem_en, and SHALL return if_rdata = 32'h00000013 (NOP) with if_rvalid one cycle later.
REQ-032 Address bits [1:0] SHALL be ignored.
REQ-033 When no request is granted, if_rdata and dbg_rdata SHALL hold their last values.

Reset
REQ-034 While rst=0, the block SHALL hold state FETCH, starvation counter 0, owner none, all grant, valid, error and mem_* outputs 0, and dbg_rdata 0.
REQ-035 While rst=0, if_rdata SHALL be 32'h00000013 (NOP).
REQ-036 Assertion of reset mid-transaction SHALL drop any pending response with no rvalid issued.
REQ-037 After reset is released, the first cycle SHALL arbitrate normally.

Structure
REQ-038 The state encoding, owner encoding and NOP constant (32'h00000013) SHALL reside in a shared package, imem_pkg.
REQ-039 The starvation counter SHALL be one sub-module, imem_starve_ctr.
REQ-040 The memory array SHALL remain outside this block.

Verification
REQ-041 Fetch-only stream: if_req=1 with addresses 0, 4, 8 -> if_rvalid one cycle after each grant, with if_rdata matching memory words 0, 1, 2.
REQ-042 Starvation: if_req and dbg_req both held with STARVE_MAX=4 -> dbg_gnt asserted in the 5th cycle, the counter returns to 0, and fetch is granted the next cycle.
REQ-043 Locked load: dbg_lock=1 with writes of 0x00500513 to addresses 0x0 and 0x4 -> if_gnt=0 throughout, FETCH resumes one cycle after dbg_lock falls, and a read of 0x0 returns 0x00500513.
REQ-044 Out of range: debug read of 0x400 -> no mem_en, and dbg_err=1, dbg_rvalid=1, dbg_rdata=0 on the next cycle; fetch of 0x400 -> if_rdata=0x00000013.
REQ-045 Reset during a granted debug read -> no dbg_rvalid, all outputs at their reset values, and if_rdata=0x00000013 until rst returns to 1.
